sqrt_table_loader: RTL and testbench
====================================

# sqrt_table_loader

Runtime writer for the 1024 × 36-bit square-root lookup table used by the multi-cycle FPU `fsqrt` path. It accepts a byte stream from the UART receive path, assembles 36-bit entries and writes them sequentially into the table RAM write port. It then checks a trailing XOR checksum. The FPU can therefore run with a table other than the one baked in at synthesis. The block sits between the UART byte FIFO and the write port of the table RAM; the FPU read port is untouched.

## Interface
- `DEPTH`, 1024, number of table entries.
- `AW`, 10, table address width, equal to clog2(DEPTH).
- `DW`, 36, entry width: [35:13] is the 23-bit constant term; [12:0] is the gradient low bits, with the gradient's leading 1 implicit.
- `BPE`, 5, bytes per entry, equal to ceil(DW/8).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a load; honoured only in IDLE or DONE.
- `in_valid` input 1: byte available from upstream.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `wr_en` output 1: table write strobe.
- `wr_addr` output AW: table write address.
- `wr_data` output DW: table write data.
- `busy` output 1: load in progress (LOAD or CHECK).
- `done` output 1: load finished; level, held until the next accepted `start`.
- `err` output 1: sticky error, valid when `done`=1; cleared by an accepted `start`.

## Operation
- States: IDLE, LOAD, CHECK, DONE.
- IDLE: `in_ready`=0. An accepted `start` moves to LOAD and clears the following: byte counter, entry address, checksum, `err` and `done`.
- LOAD: `in_ready`=1.
  - Each transferred byte is XORed into an 8-bit running checksum and placed in the byte slot given by the byte counter (0..BPE-1), little-endian.
  - Entry assembly: `wr_data` = {b4[3:0], b3, b2, b1, b0}.
  - Byte counter wraps BPE-1 → 0. When slot BPE-1 is accepted, the assembled entry is written at the current address and the address increments.
  - Nonzero b4[7:4]: those bits are discarded, the entry is still written, and `err` is set.
  - After the entry at address DEPTH-1 is accepted, go to CHECK. The address does not wrap to 0 for writing.
- CHECK: `in_ready`=1 for exactly one byte. If the running XOR of all DEPTH×BPE payload bytes ≠ this byte, set `err`. Go to DONE.
- DONE: `in_ready`=0, `done`=1. An accepted `start` restarts the load as from IDLE.
- `start` while `busy`=1 is ignored.
- `in_valid`=0 stalls with no state change; there is no timeout.
- A transfer while `in_ready`=0 does not occur by definition. Upstream bytes arriving in IDLE or DONE stay upstream.
- Reset mid-load: all state returns to reset values immediately. Table contents already written remain and are not reverted.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `in_ready` and `busy` rise the cycle after `start` is sampled.
- All outputs are registered.
  - `wr_en` is high for exactly one cycle, the cycle after the edge that accepts the entry's last byte.
  - `wr_addr` and `wr_data` are stable during that cycle.
- Write rate: at most one write per BPE accepted bytes. With `in_valid` held high, a full load takes 1 + DEPTH×BPE + 1 cycles from `start` to `done`.
- `done` rises the cycle after the checksum byte is accepted. `busy` falls in the same cycle.
- `err` from a bad b4 is visible the cycle after that byte is accepted. `err` from a checksum mismatch is visible the cycle `done` rises.

## Structure
- Shared FPU package holds:
  - `SQRT_TBL_DEPTH`, `SQRT_TBL_AW`, `SQRT_TBL_DW`;
  - the field split constants (constant [35:13], gradient [12:0]);
  - the state enum `sqrt_ld_state_t`.
- No sub-module is required. Byte assembly and checksum are inline.
- The consuming table RAM gains one synchronous write port driven by `wr_*`.

## Test plan
- Full load, 1024 entries where entry i = {4'h0, 32'(i×3)}, correct checksum, `in_valid` always high → 1024 `wr_en` pulses, addresses 0..1023 in order, matching data, `done`=1, `err`=0 at cycle 5122.
- Same stream with the checksum byte XORed with 8'h01 → all 1024 writes occur, `done`=1, `err`=1.
- Entry 7 with b4=8'hA3 → `wr_data`@7 = 36'h3_xxxx_xxxx (upper nibble dropped), `err`=1 the next cycle, load completes.
- Random `in_valid` gaps (50% duty) → identical write sequence to the first test, no extra or missing `wr_en`.
- `rstn` low after 2000 bytes, then `start` and a full load → `wr_addr` restarts at 0, byte slot at 0, checksum fresh, `err`=0.
- `start` pulsed while `busy`, and again after `done` → the first is ignored; the second clears `done`/`err` and reloads from address 0.

Source files
------------

// File: rtl/sqrt_table_loader_pkg.sv
// sqrt_table_loader_pkg: shared FPU square-root table geometry, field split and loader states.
package sqrt_table_loader_pkg;
  localparam int SQRT_TBL_DEPTH = 1024;
  localparam int SQRT_TBL_AW = 10;
  localparam int SQRT_TBL_DW = 36;
  localparam int SQRT_TBL_BPE = 5;
  localparam int SQRT_TBL_CONST_MSB = 35;
  localparam int SQRT_TBL_CONST_LSB = 13;
  localparam int SQRT_TBL_GRAD_MSB = 12;
  localparam int SQRT_TBL_GRAD_LSB = 0;
  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_CHECK,
    LD_DONE
  } sqrt_ld_state_t;
endpackage

// File: rtl/sqrt_table_loader.sv
// sqrt_table_loader: assembles little-endian byte stream into table entries, writes them
// sequentially and verifies a trailing XOR checksum.
module sqrt_table_loader
  import sqrt_table_loader_pkg::*;
#(
  parameter int DEPTH = SQRT_TBL_DEPTH,
  parameter int AW = SQRT_TBL_AW,
  parameter int DW = SQRT_TBL_DW,
  parameter int BPE = SQRT_TBL_BPE
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int TB = DW - (BPE - 1) * 8;
  localparam int CW = $clog2(BPE);
  sqrt_ld_state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;
  logic [(BPE-1)*8-1:0] acc;
  logic [7:0] csum;
  logic go, xfer, load_xfer, last_byte;
  assign go = start && (state == LD_IDLE || state == LD_DONE);
  assign xfer = in_valid && in_ready;
  assign load_xfer = xfer && state == LD_LOAD;
  assign last_byte = load_xfer && cnt == CW'(BPE - 1);
  always_comb begin
    state_nx = state;
    state_nx = go ? LD_LOAD
             : (last_byte && addr == AW'(DEPTH - 1)) ? LD_CHECK
             : (xfer && state == LD_CHECK) ? LD_DONE
             : state;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= LD_IDLE;
    else state <= state_nx;
  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cnt <= '0;
      addr <= '0;
      acc <= '0;
      csum <= '0;
    end else begin
      in_ready <= state_nx == LD_LOAD || state_nx == LD_CHECK;
      busy <= state_nx == LD_LOAD || state_nx == LD_CHECK;
      done <= state_nx == LD_DONE;
      wr_en <= last_byte;
      if (go) begin
        cnt <= '0;
        addr <= '0;
        csum <= '0;
        err <= 1'b0;
      end else if (load_xfer) begin
        csum <= csum ^ in_data;
        cnt <= last_byte ? '0 : cnt + 1'b1;
        acc <= {in_data, acc[(BPE-1)*8-1:8]};
        if (last_byte) begin
          wr_addr <= addr;
          wr_data <= {in_data[TB-1:0], acc};
          addr <= addr + 1'b1;
          if (|in_data[7:TB]) err <= 1'b1;
        end
      end else if (xfer && state == LD_CHECK && csum != in_data) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sqrt_table_loader.sv
// tb_sqrt_table_loader: directed full-table loads checking writes, checksum, timing and restarts.
module tb_sqrt_table_loader;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, wr_en, busy, done, err;
  logic [9:0] wr_addr;
  logic [35:0] wr_data;
  logic [35:0] exp_mem [1024];
  int n_cmp = 0, n_err = 0, wcnt = 0, cyc = 0, c0 = 0;
  sqrt_table_loader dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rstn && wr_en) begin
      chk("wr_addr", 64'(wr_addr), 64'(wcnt));
      chk("wr_data", 64'(wr_data), wcnt < 1024 ? 64'(exp_mem[wcnt]) : 64'hdead);
      wcnt++;
    end
  task automatic send(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps)
      while ($urandom_range(1) == 1) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) chk("rdy_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic run_load(input bit bad7, input bit gaps, input logic [7:0] flip,
                          input int stop_at, input int busy_start_at);
    logic [7:0] cs = 8'h00;
    logic [7:0] b;
    logic [39:0] e;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 36'(i * 3);
    if (bad7) exp_mem[7] = 36'h3_0000_0015;
    wcnt = 0;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_up", 64'(busy), 64'd1);
    chk("rdy_up", 64'(in_ready), 64'd1);
    chk("done_clr", 64'(done), 64'd0);
    chk("err_clr", 64'(err), 64'd0);
    for (int i = 0; i < 1024; i++) begin
      e = 40'(i * 3);
      for (int k = 0; k < 5; k++) begin
        if (i * 5 + k == stop_at) return;
        b = (bad7 && i == 7 && k == 4) ? 8'hA3 : e[k*8 +: 8];
        if (i * 5 + k == busy_start_at) start = 1'b1;
        cs ^= b;
        send(b, gaps);
        start = 1'b0;
      end
      if (bad7 && i == 6) chk("err_pre_b4", 64'(err), 64'd0);
      if (bad7 && i == 7) chk("err_b4", 64'(err), 64'd1);
    end
    chk("done_pre", 64'(done), 64'd0);
    chk("busy_check", 64'(busy), 64'd1);
    send(cs ^ flip, gaps);
    chk("done", 64'(done), 64'd1);
    chk("busy_down", 64'(busy), 64'd0);
    chk("rdy_down", 64'(in_ready), 64'd0);
    chk("err", 64'(err), 64'((flip != 8'h00) || bad7));
    chk("n_writes", 64'(wcnt), 64'd1024);
    if (!gaps) chk("cycles", 64'(cyc - c0), 64'd5122);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = 8'h55;
    @(posedge clk); #1;
    chk("idle_rdy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    run_load(1'b0, 1'b0, 8'h00, -1, -1);
    run_load(1'b0, 1'b0, 8'h01, -1, -1);
    run_load(1'b0, 1'b0, 8'h00, -1, 300);
    run_load(1'b1, 1'b0, 8'h00, -1, -1);
    run_load(1'b0, 1'b1, 8'h00, -1, -1);
    run_load(1'b0, 1'b0, 8'h00, 2000, -1);
    chk("mid_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #2;
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_rdy", 64'(in_ready), 64'd0);
    chk("async_addr", 64'(wr_addr), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_load(1'b0, 1'b0, 8'h00, -1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
